// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and state encoding for the instruction memory loader
package imem_pkg;

    // The ROM indexes words as (PC >> 2) - 0x400, so word 0 must sit at PC 0x1000.
    localparam logic [31:0] PC_BASE     = 32'h0000_1000;
    localparam int unsigned DEPTH_WORDS = 65536;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - boot byte stream and instruction memory write port
interface imem_loader_if #(
    parameter int AW = 16
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - gathers four stream bytes into a little-endian word
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_done
);
    logic [1:0]  bc;
    logic [23:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc <= 2'd0;
            sh <= 24'd0;
        end else if (clr) begin
            bc <= 2'd0;
            sh <= 24'd0;
        end else if (en) begin
            bc <= bc + 2'd1;
            sh <= {data, sh[23:8]};
        end
    end

    // The completed word includes the byte being accepted, so it is usable on that same edge.
    assign word      = {data, sh};
    assign word_done = en && (bc == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - fills instruction memory from a checksummed byte stream, gates core reset
module imem_loader
    import imem_pkg::*;
#(
    parameter logic [31:0] PC_BASE     = imem_pkg::PC_BASE,
    parameter int unsigned DEPTH_WORDS = imem_pkg::DEPTH_WORDS,
    parameter int          AW          = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    imem_loader_if.master  bus,
    output logic           cpu_rst_n,
    output logic           busy,
    output logic           done,
    output logic           err
);
    if (PC_BASE[1:0] != 2'b00 || (64'd1 << AW) < 64'(DEPTH_WORDS)) begin : g_bad_params
        $error("imem_loader: PC_BASE must be word aligned and AW must cover DEPTH_WORDS");
    end

    loader_state_t state, state_nx;
    logic          accept;
    logic          clr;
    logic          word_done;
    logic [31:0]   word;
    logic [31:0]   n;
    logic [31:0]   sum;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          we;
    logic          crst;

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .en        (accept),
        .data      (bus.in_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        clr          = 1'b0;
        bus.in_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                clr = 1'b1;
                if (start) state_nx = ST_LEN;
            end
            ST_LEN: begin
                busy = 1'b1;
                if (word_done) begin
                    if (word == 32'd0)              state_nx = ST_CSUM;
                    else if (word > DEPTH_WORDS)    state_nx = ST_ERR;
                    else                            state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                busy = 1'b1;
                if (word_done && 32'(waddr) == n - 32'd1) state_nx = ST_CSUM;
            end
            ST_CSUM: begin
                busy = 1'b1;
                if (word_done) state_nx = (word == sum) ? ST_DONE : ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                done = (state == ST_DONE);
                err  = (state == ST_ERR);
                if (start) begin
                    clr      = 1'b1;
                    state_nx = ST_LEN;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        bus.in_ready = busy;
    end

    assign accept = bus.in_valid && busy;

    // The write index advances on the edge after its write, always before the next word completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n     <= 32'd0;
            sum   <= 32'd0;
            waddr <= '0;
            wdata <= 32'd0;
            we    <= 1'b0;
            crst  <= 1'b0;
        end else begin
            we   <= (state == ST_DATA) && word_done;
            crst <= (state_nx == ST_DONE);
            if (clr) begin
                n     <= 32'd0;
                sum   <= 32'd0;
                waddr <= '0;
            end else begin
                if (state == ST_LEN && word_done) n <= word;
                if (state == ST_DATA && word_done) begin
                    wdata <= word;
                    sum   <= sum + word;
                end
                if (we) waddr <= waddr + AW'(1);
            end
        end
    end

    assign bus.mem_we    = we;
    assign bus.mem_waddr = waddr;
    assign bus.mem_wdata = wdata;
    assign cpu_rst_n     = crst;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;
    import imem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_rst_n, busy, done, err;

    imem_loader_if #(.AW(16)) bus ();

    imem_loader #(.AW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit gaps  = 1'b0;
    logic [31:0] prog[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr_q.push_back(32'(bus.mem_waddr));
            wr_data_q.push_back(bus.mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  waited = 0;
        bit  sent   = 1'b0;
        while (!sent) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = b;
                if (bus.in_ready) begin
                    @(posedge clk);
                    sent = 1'b1;
                end
            end
            waited++;
            if (!sent && waited > 50) begin
                total++;
                bad++;
                $error("FAIL send_timeout: observed in_ready=%b expected=1", bus.in_ready);
                bus.in_valid = 1'b0;
                sent = 1'b1;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic end_stream();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_bit({tag, "_busy_after_start"}, busy, 1'b1);
        check_bit({tag, "_done_cleared"}, done, 1'b0);
        check_bit({tag, "_err_cleared"}, err, 1'b0);
        check_bit({tag, "_cpu_rst_after_start"}, cpu_rst_n, 1'b0);
    endtask

    task automatic check_writes(input string tag, input int exp_cnt);
        check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(exp_cnt));
        for (int i = 0; i < exp_cnt && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_wr%0d_addr", tag, i), wr_addr_q[i], 32'(i));
            check($sformatf("%s_wr%0d_data", tag, i), wr_data_q[i], prog[i]);
        end
    endtask

    // Reference: words land at consecutive indices, success iff checksum equals the 32-bit sum.
    task automatic run_load(input string tag, input logic [31:0] n, input logic [31:0] csum);
        logic [31:0] s;
        bit          ok;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start(tag);
        send_word(n);
        if (n > DEPTH_WORDS) begin
            end_stream();
            check_bit({tag, "_ovf_err"}, err, 1'b1);
            check_bit({tag, "_ovf_busy"}, busy, 1'b0);
            check_bit({tag, "_ovf_cpu_rst"}, cpu_rst_n, 1'b0);
            @(posedge clk);
            #1;
            check({tag, "_ovf_wr_count"}, 32'(wr_addr_q.size()), 32'd0);
            return;
        end
        foreach (prog[i]) send_word(prog[i]);
        send_word(csum);
        end_stream();
        s = 32'd0;
        foreach (prog[i]) s = s + prog[i];
        ok = (csum == s);
        check_bit({tag, "_done"}, done, ok);
        check_bit({tag, "_err"}, err, !ok);
        check_bit({tag, "_cpu_rst_n"}, cpu_rst_n, ok);
        check_bit({tag, "_busy_end"}, busy, 1'b0);
        check_bit({tag, "_in_ready_end"}, bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        check_writes(tag, prog.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] s;
        int          nw;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("rst_cpu_rst_n", cpu_rst_n, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check_bit("rst_in_ready", bus.in_ready, 1'b0);
        check_bit("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_waddr", 32'(bus.mem_waddr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("idle_after_rst_busy", busy, 1'b0);

        prog = '{32'h0000_0513, 32'h0010_0593};
        run_load("two_word", 32'd2, 32'h0010_0AA6);

        prog.delete();
        run_load("zero_len", 32'd0, 32'd0);

        prog = '{32'h0000_0513, 32'h0010_0593};
        run_load("bad_csum", 32'd2, 32'd0);
        run_load("reload", 32'd2, 32'h0010_0AA6);

        gaps = 1'b1;
        run_load("two_word_gaps", 32'd2, 32'h0010_0AA6);
        gaps = 1'b0;

        prog.delete();
        run_load("overflow", 32'h0001_0001, 32'd0);

        // Full-depth length is legal; abort it partway with an asynchronous reset.
        prog = '{32'hDEAD_BEEF, 32'h0123_4567};
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start("abort");
        send_word(32'h0001_0000);
        end_stream();
        check_bit("full_depth_err", err, 1'b0);
        check_bit("full_depth_busy", busy, 1'b1);
        send_word(prog[0]);
        send_word(prog[1]);
        send_byte(8'hAA);
        send_byte(8'h55);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_in_ready", bus.in_ready, 1'b0);
        check_bit("abort_mem_we", bus.mem_we, 1'b0);
        check("abort_mem_waddr", 32'(bus.mem_waddr), 32'd0);
        check("abort_mem_wdata", bus.mem_wdata, 32'd0);
        check_bit("abort_cpu_rst_n", cpu_rst_n, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check_bit("abort_idle_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        check_writes("abort", 2);

        gaps = 1'b1;
        for (int it = 0; it < 8; it++) begin
            nw = $urandom_range(1, 6);
            prog.delete();
            for (int k = 0; k < nw; k++) prog.push_back($urandom);
            s = 32'd0;
            foreach (prog[k]) s = s + prog[k];
            if ($urandom_range(0, 1) == 1) s = s + 32'($urandom_range(1, 1000));
            run_load($sformatf("rand%0d", it), 32'(nw), s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
